// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receiver and its FIFO.
// Optional feature macro: UART_RX_PARITY_EN adds the PAR state (even parity).
package uart_pkg;

  localparam int DATA_W         = 8;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_DIV_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PAR,
`endif
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous first-word-fall-through byte FIFO, power-of-two depth.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_pushData,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [AW:0]       r_count;
  logic              w_empty;
  logic              w_full;
  logic              w_doRd;
  logic              w_doWr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_doRd  = i_pop && !w_empty;
  assign w_doWr  = i_push && (!w_full || w_doRd);

  // Pointers wrap naturally at the power-of-two depth; occupancy tracks push/pop balance
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doWr) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doRd) r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doWr, w_doRd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset because empty slots are never presented at the output
  always_ff @(posedge clk) begin
    if (w_doWr) r_mem[r_wrPtr] <= i_pushData;
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rdPtr];
  assign o_valid = !w_empty;
  assign o_count = r_count;
  assign o_full  = w_full;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling-free UART receiver (8 data bits, 1 stop) feeding a FWFT FIFO.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit and the par_err flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DIV_W      = DEF_DIV_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          RX,
  input  logic [DIV_W-1:0]              div,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  input  logic                          clr_err,
  output logic                          ovr_err,
  output logic                          frm_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                          par_err
`endif
);

  uart_state_t       r_state, w_stateNext;
  logic              r_rxMeta, r_rxSync;
  logic [1:0]        r_vld;
  logic              r_armed, w_armedNext;
  logic [DIV_W-1:0]  r_div, w_divNext;
  logic [DIV_W-1:0]  r_cnt, w_cntNext;
  logic [2:0]        r_bitIdx, w_bitNext;
  logic [DATA_W-1:0] r_shift, w_shiftNext;
  logic              r_ovr, r_frm;
  logic              w_push, w_frmSet, w_ovrSet, w_full, w_expired;
`ifdef UART_RX_PARITY_EN
  logic              r_parOk, w_parOkNext, w_parSet, r_par;
`endif

  assign w_expired = (r_cnt == '0);

  // Two-flop synchronizer; r_vld marks when r_rxSync reflects the real line rather than reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
      r_vld    <= 2'b00;
    end else begin
      r_rxMeta <= RX;
      r_rxSync <= r_rxMeta;
      r_vld    <= {r_vld[0], 1'b1};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  // Next-state and datapath decisions; a start is only taken once the line was seen idle-high
  always_comb begin
    w_stateNext = r_state;
    w_armedNext = r_armed;
    w_divNext   = r_div;
    w_cntNext   = r_cnt;
    w_bitNext   = r_bitIdx;
    w_shiftNext = r_shift;
    w_push      = 1'b0;
    w_frmSet    = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_parOkNext = r_parOk;
    w_parSet    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (r_armed && !r_rxSync) begin
          w_stateNext = START;
          w_armedNext = 1'b0;
          w_divNext   = div;
          w_cntNext   = div >> 1;
        end else if (r_vld[1] && r_rxSync) begin
          w_armedNext = 1'b1;
        end
      end
      START: begin
        if (!w_expired) begin
          w_cntNext = r_cnt - 1'b1;
        end else if (!r_rxSync) begin
          w_stateNext = DATA;
          w_cntNext   = r_div;
          w_bitNext   = '0;
        end else begin
          w_stateNext = IDLE;
        end
      end
      DATA: begin
        if (!w_expired) begin
          w_cntNext = r_cnt - 1'b1;
        end else begin
          w_shiftNext = {r_rxSync, r_shift[DATA_W-1:1]};
          w_cntNext   = r_div;
          w_bitNext   = r_bitIdx + 1'b1;
          if (r_bitIdx == 3'(DATA_W-1)) begin
`ifdef UART_RX_PARITY_EN
            w_stateNext = PAR;
`else
            w_stateNext = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PAR: begin
        if (!w_expired) begin
          w_cntNext = r_cnt - 1'b1;
        end else begin
          w_parOkNext = (r_rxSync == ^r_shift);
          w_parSet    = (r_rxSync != ^r_shift);
          w_cntNext   = r_div;
          w_stateNext = STOP;
        end
      end
`endif
      STOP: begin
        if (!w_expired) begin
          w_cntNext = r_cnt - 1'b1;
        end else begin
          w_stateNext = IDLE;
          if (r_rxSync) begin
`ifdef UART_RX_PARITY_EN
            w_push = r_parOk;
`else
            w_push = 1'b1;
`endif
          end else begin
            w_frmSet = 1'b1;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Frame datapath registers follow the values chosen above
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_armed  <= 1'b0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
`ifdef UART_RX_PARITY_EN
      r_parOk  <= 1'b1;
`endif
    end else begin
      r_armed  <= w_armedNext;
      r_div    <= w_divNext;
      r_cnt    <= w_cntNext;
      r_bitIdx <= w_bitNext;
      r_shift  <= w_shiftNext;
`ifdef UART_RX_PARITY_EN
      r_parOk  <= w_parOkNext;
`endif
    end
  end

  assign w_ovrSet = w_push && w_full && !rd_en;

  // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovr <= 1'b0;
      r_frm <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par <= 1'b0;
`endif
    end else begin
      if (w_ovrSet)     r_ovr <= 1'b1;
      else if (clr_err) r_ovr <= 1'b0;
      if (w_frmSet)     r_frm <= 1'b1;
      else if (clr_err) r_frm <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (w_parSet)     r_par <= 1'b1;
      else if (clr_err) r_par <= 1'b0;
`endif
    end
  end

  assign ovr_err = r_ovr;
  assign frm_err = r_frm;
`ifdef UART_RX_PARITY_EN
  assign par_err = r_par;
`endif

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_pushData(r_shift),
    .i_pop     (rd_en),
    .o_data    (rd_data),
    .o_valid   (rd_valid),
    .o_count   (count),
    .o_full    (w_full)
  );

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a queue-based model of the receive FIFO and error flags.
// Build with UART_RX_PARITY_EN defined to exercise the parity variant as well.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DEPTH = 16;
  localparam int DIV_W = 16;

  logic                     clk     = 1'b0;
  logic                     reset   = 1'b0;
  logic                     RX      = 1'b1;
  logic                     rd_en   = 1'b0;
  logic                     clr_err = 1'b0;
  logic [DIV_W-1:0]         div     = 16'd207;
  logic [7:0]               rd_data;
  logic                     rd_valid;
  logic [$clog2(DEPTH):0]   count;
  logic                     ovr_err;
  logic                     frm_err;
`ifdef UART_RX_PARITY_EN
  logic                     par_err;
`endif

  int          nChecks = 0;
  int          nFail   = 0;
  byte unsigned expQ[$];
  bit          expOvr  = 1'b0;
  bit          expFrm  = 1'b0;
  bit          expPar  = 1'b0;
  bit          checkEn = 1'b0;
  int          riseIdx;

  uart_rx #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .RX      (RX),
    .div     (div),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .count   (count),
    .clr_err (clr_err),
    .ovr_err (ovr_err),
    .frm_err (frm_err)
`ifdef UART_RX_PARITY_EN
    ,
    .par_err (par_err)
`endif
  );

  always #5 clk = ~clk;

  // Single comparison point: every check goes through here and steps the counters
  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every settled cycle, outputs must match the model (masked only around a frame's stop bit)
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("rd_valid", int'(rd_valid), int'(expQ.size() != 0));
      if (expQ.size() != 0) checkOutput("rd_data", int'(rd_data), int'(expQ[0]));
      checkOutput("count", int'(count), expQ.size());
      checkOutput("ovr_err", int'(ovr_err), int'(expOvr));
      checkOutput("frm_err", int'(frm_err), int'(expFrm));
`ifdef UART_RX_PARITY_EN
      checkOutput("par_err", int'(par_err), int'(expPar));
`endif
    end
  end

  // Drive one frame of d+1 clocks per bit; act 1 = rd_en, act 2 = clr_err in the push cycle.
  // The received byte becomes visible 4+(d>>1) clocks into the stop bit (sync + half-bit + 1).
  task automatic applyStimulus(input byte unsigned data, input bit stopBit, input bit parBit,
                               input int d, input int act);
    bit parOk;
    bit wasFull;
    bit popping;
    riseIdx = -1;
    @(negedge clk);
    div = DIV_W'(d);
    RX  = 1'b0;
    repeat (d + 1) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      RX = data[b];
      repeat (d + 1) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    RX = parBit;
    repeat (d + 1) @(negedge clk);
    parOk = (parBit == ^data);
`else
    parOk = 1'b1;
`endif
    checkEn = 1'b0;
    RX      = stopBit;
    for (int i = 0; i <= d + 3; i++) begin
      if (i == d + 1) RX = 1'b1;
      if (rd_valid && riseIdx < 0) riseIdx = i;
      rd_en   = (act == 1) && (i == 3 + (d >> 1));
      clr_err = (act == 2) && (i == 3 + (d >> 1));
      @(negedge clk);
    end
    rd_en   = 1'b0;
    clr_err = 1'b0;
    if (act == 2) begin
      expOvr = 1'b0;
      expFrm = 1'b0;
      expPar = 1'b0;
    end
    if (!parOk) expPar = 1'b1;
    wasFull = (expQ.size() == DEPTH);
    popping = (act == 1) && (expQ.size() != 0);
    if (popping) void'(expQ.pop_front());
    if (!stopBit) expFrm = 1'b1;
    else if (parOk) begin
      if (wasFull && !popping) expOvr = 1'b1;
      else expQ.push_back(data);
    end
    checkEn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic popOne;
    @(negedge clk);
    rd_en = 1'b1;
    @(posedge clk);
    if (expQ.size() != 0) void'(expQ.pop_front());
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic clrErr;
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    expOvr = 1'b0;
    expFrm = 1'b0;
    expPar = 1'b0;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic resetAll;
    checkEn = 1'b0;
    reset   = 1'b0;
    repeat (3) @(negedge clk);
    expQ.delete();
    expOvr = 1'b0;
    expFrm = 1'b0;
    expPar = 1'b0;
    checkOutput("rst_valid", int'(rd_valid), 0);
    checkOutput("rst_data", int'(rd_data), 0);
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_ovr", int'(ovr_err), 0);
    checkOutput("rst_frm", int'(frm_err), 0);
`ifdef UART_RX_PARITY_EN
    checkOutput("rst_par", int'(par_err), 0);
`endif
    reset   = 1'b1;
    checkEn = 1'b1;
  endtask

  byte unsigned patData[4] = '{8'hFF, 8'h80, 8'h01, 8'h3C};
  int           patDiv[4]  = '{3, 5, 12, 7};

  initial begin
    repeat (2) @(negedge clk);
    resetAll();
    repeat (4) @(negedge clk);

    // 0x55 at div=207: visible 4+103 clocks into the stop bit
    applyStimulus(8'h55, 1'b1, 1'b0, 207, 0);
    checkOutput("push_latency", riseIdx, 107);
    checkOutput("byte_55", int'(rd_data), 'h55);
    checkOutput("count_55", int'(count), 1);
    popOne();

    // 50-clock low glitch is a false start
    @(negedge clk);
    div = 16'd207;
    RX  = 1'b0;
    repeat (50) @(negedge clk);
    RX = 1'b1;
    repeat (300) @(negedge clk);
    checkOutput("false_start_valid", int'(rd_valid), 0);
    checkOutput("false_start_frm", int'(frm_err), 0);
    checkOutput("false_start_ovr", int'(ovr_err), 0);

    // Framing error, then clear
    applyStimulus(8'hA3, 1'b0, ^8'hA3, 7, 0);
    checkOutput("frm_set", int'(frm_err), 1);
    checkOutput("frm_count", int'(count), 0);
    clrErr();
    checkOutput("frm_clr", int'(frm_err), 0);

    // Mixed patterns and divisors, including the minimum divisor
    for (int k = 0; k < 4; k++) applyStimulus(patData[k], 1'b1, ^patData[k], patDiv[k], 0);
    checkOutput("pat_count", int'(count), 4);
    checkOutput("pat_head", int'(rd_data), 'hFF);
    applyStimulus(8'h5A, 1'b1, ^8'h5A, 7, 1);
    checkOutput("pushpop_count", int'(count), 4);
    checkOutput("pushpop_head", int'(rd_data), 'h80);
    repeat (4) popOne();
    popOne();
    checkOutput("empty_pop_count", int'(count), 0);
    checkOutput("empty_pop_valid", int'(rd_valid), 0);

    // Overrun: 17 frames into a 16-deep FIFO
    for (int k = 0; k < 17; k++) applyStimulus(8'(k), 1'b1, ^8'(k), 7, 0);
    checkOutput("ovr_count", int'(count), 16);
    checkOutput("ovr_set", int'(ovr_err), 1);
    for (int k = 0; k < 16; k++) begin
      checkOutput("ovr_drain", int'(rd_data), k);
      popOne();
    end
    clrErr();
    checkOutput("ovr_clr", int'(ovr_err), 0);

    // Full FIFO with rd_en in the 17th push cycle
    for (int k = 0; k < 16; k++) applyStimulus(8'(k), 1'b1, ^8'(k), 7, 0);
    applyStimulus(8'h10, 1'b1, ^8'h10, 7, 1);
    checkOutput("full_rw_ovr", int'(ovr_err), 0);
    checkOutput("full_rw_count", int'(count), 16);
    checkOutput("full_rw_head", int'(rd_data), 'h01);
    repeat (16) popOne();

    // clr_err in the same cycle as a framing error: set wins
    applyStimulus(8'h11, 1'b0, ^8'h11, 7, 2);
    checkOutput("set_wins", int'(frm_err), 1);

    // Reset mid-frame with the line held low across release
    applyStimulus(8'h42, 1'b1, ^8'h42, 7, 0);
    @(negedge clk);
    div = 16'd7;
    RX  = 1'b0;
    repeat (20) @(negedge clk);
    resetAll();
    repeat (30) @(negedge clk);
    RX = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("post_rst_count", int'(count), 0);
    applyStimulus(8'h9C, 1'b1, ^8'h9C, 7, 0);
    checkOutput("post_rst_byte", int'(rd_data), 'h9C);
    popOne();

`ifdef UART_RX_PARITY_EN
    applyStimulus(8'h07, 1'b1, 1'b0, 7, 0);
    checkOutput("par_set", int'(par_err), 1);
    checkOutput("par_count", int'(count), 0);
    clrErr();
    applyStimulus(8'h07, 1'b1, 1'b1, 7, 0);
    checkOutput("par_good", int'(rd_data), 'h07);
    @(negedge clk);
    div = 16'd7;
    RX  = 1'b0;
    repeat (30) @(negedge clk);
    resetAll();
    RX = 1'b1;
    repeat (6) @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule
